// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: main control unit for a 5-stage RISC-V pipeline.
// Decodes the ID-stage opcode into an 11-bit control bundle and carries it
// through ID/EX, EX/MEM and MEM/WB. Detects load-use hazards, squashes on
// EX redirects, flags unknown opcodes and counts stalls/flushes.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   id_valid          ID stage holds a real instruction
//   id_opcode         instruction[6:0]
//   id_rs1/rs2/rd     register fields of the ID instruction
//   ex_redirect       branch taken / jump resolved in EX
//   hold              global freeze (data-memory wait)
//   stall_if_id       combinational: hold PC and IF/ID
//   flush_if_id       combinational: squash IF/ID (equals ex_redirect)
//   ex/mem/wb_ctrl    bundle {Jump, JumpReg, Link, Branch, ALUOp[1:0],
//                     ALUSrc, MemRead, MemWrite, MemtoReg, RegWrite}
//   ex/mem/wb_rd      destination register per stage
//   ex_illegal        previous ID instruction had an unknown opcode
//   stall_cnt         saturating count of stall cycles
//   flush_cnt         saturating count of redirect cycles
module pipe_ctrl_unit #(
  parameter int unsigned RA_W  = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [6:0]       id_opcode,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             ex_redirect,
  input  logic             hold,
  output logic             stall_if_id,
  output logic             flush_if_id,
  output logic [10:0]      ex_ctrl,
  output logic [10:0]      mem_ctrl,
  output logic [10:0]      wb_ctrl,
  output logic [RA_W-1:0]  ex_rd,
  output logic [RA_W-1:0]  mem_rd,
  output logic [RA_W-1:0]  wb_rd,
  output logic             ex_illegal,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned CTRL_W = 11;

  // Bit positions inside the control bundle
  localparam int unsigned B_JUMP     = 10;
  localparam int unsigned B_JUMPREG  = 9;
  localparam int unsigned B_LINK     = 8;
  localparam int unsigned B_BRANCH   = 7;
  localparam int unsigned B_ALUOP_HI = 6;
  localparam int unsigned B_ALUOP_LO = 5;
  localparam int unsigned B_ALUSRC   = 4;
  localparam int unsigned B_MEMREAD  = 3;
  localparam int unsigned B_MEMWRITE = 2;
  localparam int unsigned B_MEMTOREG = 1;
  localparam int unsigned B_REGWRITE = 0;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
  logic [CTRL_W-1:0] mem_ctrl_q, mem_ctrl_d;
  logic [CTRL_W-1:0] wb_ctrl_q, wb_ctrl_d;
  logic [RA_W-1:0]   ex_rd_q, ex_rd_d;
  logic [RA_W-1:0]   mem_rd_q, mem_rd_d;
  logic [RA_W-1:0]   wb_rd_q, wb_rd_d;
  logic              ex_illegal_q, ex_illegal_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic [CTRL_W-1:0] dec_raw_c;
  logic [CTRL_W-1:0] dec_ctrl_c;
  logic              dec_known_c;
  logic              uses_rs1_c;
  logic              uses_rs2_c;
  logic              load_use_c;

  // Opcode decode table and register-use flags
  always_comb begin
    dec_raw_c   = '0;
    dec_known_c = 1'b1;
    uses_rs1_c  = 1'b0;
    uses_rs2_c  = 1'b0;
    unique case (id_opcode)
      OP_R: begin
        dec_raw_c[B_REGWRITE]             = 1'b1;
        dec_raw_c[B_ALUOP_HI:B_ALUOP_LO]  = 2'b10;
        uses_rs1_c = 1'b1;
        uses_rs2_c = 1'b1;
      end
      OP_I: begin
        dec_raw_c[B_ALUSRC]               = 1'b1;
        dec_raw_c[B_REGWRITE]             = 1'b1;
        dec_raw_c[B_ALUOP_HI:B_ALUOP_LO]  = 2'b10;
        uses_rs1_c = 1'b1;
      end
      OP_LUI: begin
        dec_raw_c[B_ALUSRC]               = 1'b1;
        dec_raw_c[B_REGWRITE]             = 1'b1;
        dec_raw_c[B_ALUOP_HI:B_ALUOP_LO]  = 2'b11;
      end
      OP_AUIPC: begin
        dec_raw_c[B_ALUSRC]               = 1'b1;
        dec_raw_c[B_REGWRITE]             = 1'b1;
      end
      OP_LW: begin
        dec_raw_c[B_ALUSRC]               = 1'b1;
        dec_raw_c[B_MEMREAD]              = 1'b1;
        dec_raw_c[B_MEMTOREG]             = 1'b1;
        dec_raw_c[B_REGWRITE]             = 1'b1;
        uses_rs1_c = 1'b1;
      end
      OP_SW: begin
        dec_raw_c[B_ALUSRC]               = 1'b1;
        dec_raw_c[B_MEMWRITE]             = 1'b1;
        uses_rs1_c = 1'b1;
        uses_rs2_c = 1'b1;
      end
      OP_BR: begin
        dec_raw_c[B_BRANCH]               = 1'b1;
        dec_raw_c[B_ALUOP_HI:B_ALUOP_LO]  = 2'b01;
        uses_rs1_c = 1'b1;
        uses_rs2_c = 1'b1;
      end
      OP_JAL: begin
        dec_raw_c[B_JUMP]                 = 1'b1;
        dec_raw_c[B_LINK]                 = 1'b1;
        dec_raw_c[B_REGWRITE]             = 1'b1;
      end
      OP_JALR: begin
        dec_raw_c[B_JUMP]                 = 1'b1;
        dec_raw_c[B_JUMPREG]              = 1'b1;
        dec_raw_c[B_LINK]                 = 1'b1;
        dec_raw_c[B_ALUSRC]               = 1'b1;
        dec_raw_c[B_REGWRITE]             = 1'b1;
        uses_rs1_c = 1'b1;
      end
      default: dec_known_c = 1'b0;
    endcase
  end

  // Valid-qualified bundle; writes to x0 are suppressed
  always_comb begin
    dec_ctrl_c = '0;
    if (id_valid && dec_known_c) begin
      dec_ctrl_c             = dec_raw_c;
      dec_ctrl_c[B_REGWRITE] = dec_raw_c[B_REGWRITE] & (id_rd != '0);
    end
  end

  // Load in EX whose destination the ID instruction actually reads
  always_comb begin
    load_use_c = ex_ctrl_q[B_MEMREAD] && (ex_rd_q != '0) && id_valid &&
                 ((uses_rs1_c && (id_rs1 == ex_rd_q)) ||
                  (uses_rs2_c && (id_rs2 == ex_rd_q)));
  end

  // Redirect wins over stall: the stalled instruction is squashed anyway
  assign stall_if_id = load_use_c & ~ex_redirect;
  assign flush_if_id = ex_redirect;

  // Next-state for stage registers and counters
  always_comb begin
    ex_ctrl_d    = '0;
    ex_rd_d      = '0;
    ex_illegal_d = 1'b0;
    mem_ctrl_d   = ex_ctrl_q;
    mem_rd_d     = ex_rd_q;
    wb_ctrl_d    = mem_ctrl_q;
    wb_rd_d      = mem_rd_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;

    if (!ex_redirect && !load_use_c) begin
      ex_ctrl_d    = dec_ctrl_c;
      ex_rd_d      = (id_valid && dec_known_c) ? id_rd : '0;
      ex_illegal_d = id_valid & ~dec_known_c;
    end

    if (stall_if_id && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (ex_redirect && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // Pipeline registers; reset overrides hold, hold freezes everything
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_ctrl_q    <= '0;
      mem_ctrl_q   <= '0;
      wb_ctrl_q    <= '0;
      ex_rd_q      <= '0;
      mem_rd_q     <= '0;
      wb_rd_q      <= '0;
      ex_illegal_q <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else if (!hold) begin
      ex_ctrl_q    <= ex_ctrl_d;
      mem_ctrl_q   <= mem_ctrl_d;
      wb_ctrl_q    <= wb_ctrl_d;
      ex_rd_q      <= ex_rd_d;
      mem_rd_q     <= mem_rd_d;
      wb_rd_q      <= wb_rd_d;
      ex_illegal_q <= ex_illegal_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign ex_ctrl    = ex_ctrl_q;
  assign mem_ctrl   = mem_ctrl_q;
  assign wb_ctrl    = wb_ctrl_q;
  assign ex_rd      = ex_rd_q;
  assign mem_rd     = mem_rd_q;
  assign wb_rd      = wb_rd_q;
  assign ex_illegal = ex_illegal_q;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule
